pc_unit_ras: RTL and testbench
==============================

Name: pc_unit_ras

Overview:
Parametrised program-counter unit for the fetch stage, succeeding the single fixed-width PC register. It holds the PC and supports hold, sequential advance, taken branch/jump redirect, and call/return through an internal circular return-address stack (RAS). Sticky error flags cover RAS overflow and underflow. It drives the instruction-memory address and receives redirects from decode/execute.

Parameters:
WIDTH, 32, PC width in bits.
STEP, 1, increment added per sequential advance; result taken modulo 2^WIDTH.
RESET_VECTOR, {WIDTH{1'b1}}, PC value after reset; the default all-ones makes the first advance yield 0.
RAS_DEPTH, 4, number of return-address entries; legal range is 2 to 16.

Ports:
clock  input  1  single clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
write  input  1  advance enable; 0 holds all state (stall).
branch_taken  input  1  redirect PC to branch_target.
branch_target  input  WIDTH  redirect/call target address.
call  input  1  push return address (pc_out+STEP); valid only with branch_taken.
ret  input  1  pop RAS top into PC.
pc_out  output  WIDTH  registered current PC.
ras_count  output  clog2(RAS_DEPTH+1)  valid entries in RAS.
ras_empty  output  1  ras_count==0 (combinational from count).
ras_full  output  1  ras_count==RAS_DEPTH (combinational from count).
overflow_err  output  1  sticky; set on push while full.
underflow_err  output  1  sticky; set on ret while empty.

Behaviour:
- Reset (synchronous, highest priority, including mid-operation): pc_out=RESET_VECTOR, ras_count=0, top pointer=0, overflow_err=0, underflow_err=0. RAS storage contents are don't-care.
- write=0: pc_out, RAS, count and flags hold; all other inputs are ignored.
- write=1, evaluated in priority order each cycle:
  1. ret=1 and call=1 and branch_taken=1: pc_out<=branch_target. If RAS is non-empty, replace top with pc_out+STEP; count unchanged. If RAS is empty, act as a plain call.
  2. ret=1, RAS non-empty: pc_out<=top entry; pop (count-1). branch_taken is ignored.
  3. ret=1, RAS empty: pc_out<=pc_out+STEP; underflow_err<=1; count stays 0.
  4. branch_taken=1 and call=1: pc_out<=branch_target; push pc_out+STEP.
     - If not full: count+1.
     - If full: overwrite the oldest entry circularly; count stays RAS_DEPTH; overflow_err<=1.
  5. branch_taken=1: pc_out<=branch_target.
  6. Otherwise (including call=1 without branch_taken, which is ignored): pc_out<=pc_out+STEP.
- Latency: one cycle. pc_out reflects the decision on the next rising edge. The RAS top is readable the cycle after a push.
- Arithmetic: pc_out+STEP is truncated to WIDTH and wraps modulo 2^WIDTH. Return addresses are stored at full WIDTH.
- RAS is a circular buffer with a top pointer modulo RAS_DEPTH. Pops after an overflow return the most recent RAS_DEPTH addresses; the oldest address is lost.
- Error flags clear only on reset.

Test Plan:
1. Reset, then write=1 for 3 cycles (defaults) -> pc_out sequence FFFFFFFF, 0, 1, 2; all flags 0, ras_empty=1.
2. At pc_out=0x10, assert write=0 with branch_taken=1 and target 0x80 for 2 cycles -> pc_out stays 0x10, RAS unchanged. Then write=1 with branch_taken=1, target 0x80 -> pc_out=0x80 next cycle.
3. At pc_out=0x20, call with target 0x100 -> pc_out=0x100, ras_count=1. Advance twice, then ret -> pc_out=0x21, ras_count=0.
4. Five nested calls from 0x0, 0x10, 0x20, 0x30, 0x40 with RAS_DEPTH=4 -> overflow_err=1, ras_count=4. Four rets return 0x41, 0x31, 0x21, 0x11. A fifth ret -> underflow_err=1, pc_out=0x12.
5. ret+call+branch_taken together at pc_out=0x50 with target 0x200 and RAS top 0x11 -> pc_out=0x200, top=0x51, count unchanged. Then assert reset mid-sequence -> pc_out=RESET_VECTOR, count=0, both flags cleared.
6. WIDTH=8, pc_out=0xFF, STEP=4, advance -> pc_out=0x03 (wrap).

Source files
------------

// File: rtl/pc_unit_ras.sv
// pc_unit_ras: fetch-stage program counter with a circular return-address stack
module pc_unit_ras #(
    parameter int                WIDTH        = 32,
    parameter int                STEP         = 1,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = {WIDTH{1'b1}},
    parameter int                RAS_DEPTH    = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 write,
    input  logic                                 branch_taken,
    input  logic [WIDTH-1:0]                     branch_target,
    input  logic                                 call,
    input  logic                                 ret,
    output logic [WIDTH-1:0]                     pc_out,
    output logic [$clog2(RAS_DEPTH+1)-1:0]       ras_count,
    output logic                                 ras_empty,
    output logic                                 ras_full,
    output logic                                 overflow_err,
    output logic                                 underflow_err
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH+1);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_d [RAS_DEPTH];
    logic [WIDTH-1:0] seq_pc;
    logic [PW-1:0]    ptr_inc, ptr_dec;
    logic             replace, pop, push;

    // ptr_q is the next free slot; the top entry lives one slot below it
    assign seq_pc  = pc_q + WIDTH'(STEP);
    assign ptr_inc = (ptr_q == PW'(RAS_DEPTH-1)) ? '0 : ptr_q + 1'b1;
    assign ptr_dec = (ptr_q == '0) ? PW'(RAS_DEPTH-1) : ptr_q - 1'b1;
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CW'(RAS_DEPTH));
    assign replace = ret && call && branch_taken && !ras_empty;
    assign pop     = ret && !(call && branch_taken);
    assign push    = call && branch_taken && !replace;

    assign pc_out        = pc_q;
    assign ras_count     = cnt_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

    // next-state selection in priority order: replace, pop, push, branch, advance
    always_comb begin
        pc_d  = pc_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        ras_d = ras_q;
        if (write) begin
            if (replace) begin
                pc_d = branch_target;
                ras_d[ptr_dec] = seq_pc;
            end else if (pop) begin
                if (ras_empty) begin
                    pc_d  = seq_pc;
                    unf_d = 1'b1;
                end else begin
                    pc_d  = ras_q[ptr_dec];
                    ptr_d = ptr_dec;
                    cnt_d = cnt_q - 1'b1;
                end
            end else if (push) begin
                pc_d = branch_target;
                ras_d[ptr_q] = seq_pc;
                ptr_d = ptr_inc;
                cnt_d = ras_full ? cnt_q : cnt_q + 1'b1;
                ovf_d = ovf_q | ras_full;
            end else begin
                pc_d = branch_taken ? branch_target : seq_pc;
            end
        end
    end

    // control state with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q  <= RESET_VECTOR;
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // return-address storage needs no reset; count gates every read
    always_ff @(posedge clock) begin
        ras_q <= ras_d;
    end
endmodule

// File: tb/tb_pc_unit_ras.sv
// tb_pc_unit_ras: random and directed checks of pc_unit_ras against a queue-based model
module tb_pc_unit_ras;
    localparam int D = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0, write = 1'b0, branch_taken = 1'b0, call = 1'b0, ret = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] pc_out;
    logic [2:0]  ras_count;
    logic        ras_empty, ras_full, overflow_err, underflow_err;

    logic        reset8 = 1'b0, write8 = 1'b0;
    logic [7:0]  pc8, tgt8 = '0;
    logic [2:0]  cnt8;
    logic        e8, f8, o8, u8f;

    int checks = 0;
    int errors = 0;

    pc_unit_ras dut (
        .clock(clock), .reset(reset), .write(write), .branch_taken(branch_taken),
        .branch_target(branch_target), .call(call), .ret(ret), .pc_out(pc_out),
        .ras_count(ras_count), .ras_empty(ras_empty), .ras_full(ras_full),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    pc_unit_ras #(.WIDTH(8), .STEP(4), .RESET_VECTOR(8'hFF), .RAS_DEPTH(4)) dut8 (
        .clock(clock), .reset(reset8), .write(write8), .branch_taken(1'b0),
        .branch_target(tgt8), .call(1'b0), .ret(1'b0), .pc_out(pc8),
        .ras_count(cnt8), .ras_empty(e8), .ras_full(f8),
        .overflow_err(o8), .underflow_err(u8f)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the stack is just the most recent D return addresses
    logic [31:0] m_pc;
    logic [31:0] m_stk[$];
    logic        m_ovf, m_unf;
    bit          armed = 0;

    always @(posedge clock) begin
        logic [31:0] ra;
        if (reset) begin
            m_pc = 32'hFFFF_FFFF;
            m_stk.delete();
            m_ovf = 0;
            m_unf = 0;
            armed = 1;
        end else if (armed && write) begin
            ra = m_pc + 32'd1;
            if (ret && call && branch_taken && m_stk.size() > 0) begin
                m_pc = branch_target;
                m_stk[m_stk.size()-1] = ra;
            end else if (ret && !(call && branch_taken)) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin
                    m_pc = ra;
                    m_unf = 1;
                end
            end else if (call && branch_taken) begin
                m_pc = branch_target;
                if (m_stk.size() == D) begin
                    void'(m_stk.pop_front());
                    m_ovf = 1;
                end
                m_stk.push_back(ra);
            end else if (branch_taken) m_pc = branch_target;
            else m_pc = ra;
        end
    end

    // per-cycle comparison against the model
    always @(negedge clock) begin
        if (armed) begin
            check("pc_out", pc_out, m_pc);
            check("ras_count", 32'(ras_count), 32'(m_stk.size()));
            check("ras_empty", 32'(ras_empty), 32'(m_stk.size() == 0));
            check("ras_full", 32'(ras_full), 32'(m_stk.size() == D));
            check("overflow_err", 32'(overflow_err), 32'(m_ovf));
            check("underflow_err", 32'(underflow_err), 32'(m_unf));
        end
    end

    task automatic cyc(input logic w, input logic bt, input logic [31:0] t, input logic c, input logic r);
        write = w; branch_taken = bt; branch_target = t; call = c; ret = r;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clock);
        do_reset();
        check("rst_pc", pc_out, 32'hFFFF_FFFF);
        check("rst_empty", 32'(ras_empty), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 0);
            check("adv_pc", pc_out, 32'(i));
        end
        cyc(1, 1, 32'h10, 0, 0);
        cyc(0, 1, 32'h80, 0, 0);
        cyc(0, 1, 32'h80, 0, 0);
        check("stall_pc", pc_out, 32'h10);
        cyc(1, 1, 32'h80, 0, 0);
        check("branch_pc", pc_out, 32'h80);
        cyc(1, 1, 32'h20, 0, 0);
        cyc(1, 1, 32'h100, 1, 0);
        check("call_pc", pc_out, 32'h100);
        check("call_cnt", 32'(ras_count), 32'd1);
        cyc(1, 0, 0, 1, 0);
        check("call_no_bt_pc", pc_out, 32'h101);
        check("call_no_bt_cnt", 32'(ras_count), 32'd1);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1);
        check("ret_pc", pc_out, 32'h21);
        check("ret_cnt", 32'(ras_count), 32'd0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 32'(i * 16), 0, 0);
            cyc(1, 1, 32'h1000, 1, 0);
        end
        check("ovf_flag", 32'(overflow_err), 32'd1);
        check("ovf_cnt", 32'(ras_count), 32'd4);
        check("ovf_full", 32'(ras_full), 32'd1);
        for (int i = 4; i >= 1; i--) begin
            cyc(1, 1, 32'h777, 0, 1);
            check("pop_pc", pc_out, 32'(i * 16 + 1));
        end
        cyc(1, 0, 0, 0, 1);
        check("unf_flag", 32'(underflow_err), 32'd1);
        check("unf_pc", pc_out, 32'h12);
        cyc(1, 1, 32'h10, 0, 0);
        cyc(1, 1, 32'h50, 1, 0);
        cyc(1, 1, 32'h200, 1, 1);
        check("repl_pc", pc_out, 32'h200);
        check("repl_cnt", 32'(ras_count), 32'd1);
        cyc(1, 0, 0, 0, 1);
        check("repl_top", pc_out, 32'h51);
        cyc(1, 1, 32'h400, 1, 0);
        do_reset();
        check("mid_rst_pc", pc_out, 32'hFFFF_FFFF);
        check("mid_rst_cnt", 32'(ras_count), 32'd0);
        check("mid_rst_flags", 32'({overflow_err, underflow_err}), 32'd0);
        cyc(1, 1, 32'h300, 1, 1);
        check("repl_empty_pc", pc_out, 32'h300);
        check("repl_empty_cnt", 32'(ras_count), 32'd1);
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(99) == 0);
            cyc($urandom_range(7) != 0, $urandom_range(1) == 1,
                32'($urandom_range(4095)) | (32'($urandom_range(1)) << 31),
                $urandom_range(2) == 0, $urandom_range(3) == 0);
        end
        reset = 1'b0;
        reset8 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset8 = 1'b0;
        check("w8_rst_pc", 32'(pc8), 32'hFF);
        write8 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("w8_wrap_pc", 32'(pc8), 32'h03);
        write8 = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("w8_hold_pc", 32'(pc8), 32'h03);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
